// File: rtl/deser_word.sv
// deser_word: serial-to-parallel word deserializer with hold/overflow handshake.
// Define DESER_PARITY_EN to add a trailing even-parity beat per word and the word_perr output.
module deser_word #(
    parameter int WORD_W    = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1,
    localparam int BEATS    = WORD_W / LANES,
    localparam int CW       = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANES-1:0]  serial_in,
    input  logic              shift_en,
    input  logic              flush,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CW-1:0]     beat_cnt,
    output logic              overflow
`ifdef DESER_PARITY_EN
    ,
    output logic              word_perr
`endif
);
    logic [WORD_W-1:0] shreg, shreg_nxt, word_nxt;
    logic [LANES-1:0]  lanes_rev;
    logic              accept, data_beat, last_beat, done, load;

    for (genvar i = 0; i < LANES; i++) begin : g_rev
        assign lanes_rev[i] = serial_in[LANES-1-i];
    end

    assign shreg_nxt = MSB_FIRST ? {shreg[WORD_W-LANES-1:0], serial_in}
                                 : {lanes_rev, shreg[WORD_W-1:LANES]};
    assign accept    = shift_en & ~flush;
    assign last_beat = beat_cnt == CW'(BEATS - 1);
    // a finished word is only taken when the output slot is empty or draining this cycle
    assign load      = done & (~word_valid | word_ready);

`ifdef DESER_PARITY_EN
    typedef enum logic {DATA, PARITY} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk) state <= reset ? DATA : state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = flush  ? DATA :
                    accept ? ((state == DATA && last_beat) ? PARITY : DATA) : state;
    end

    // the parity beat does not shift; the word is already complete in shreg
    assign data_beat = accept & (state == DATA);
    assign done      = accept & (state == PARITY);
    assign word_nxt  = shreg;

    always_ff @(posedge clk) begin
        if (reset)
            word_perr <= 1'b0;
        else if (load)
            word_perr <= ^shreg ^ serial_in[0];
    end
`else
    assign data_beat = accept;
    assign done      = accept & last_beat;
    assign word_nxt  = shreg_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            beat_cnt   <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (flush) begin
                shreg    <= '0;
                beat_cnt <= '0;
            end else if (data_beat) begin
                shreg    <= shreg_nxt;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (load)
                word_out <= word_nxt;
            if (done & ~load)
                overflow <= 1'b1;
            word_valid <= load | (word_valid & ~word_ready);
        end
    end
endmodule

// File: tb/tb_deser_word.sv
// tb_deser_word: directed checks of deser_word in the default 1-lane MSB-first build
// and a 4-lane LSB-first build.
module tb_deser_word;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, shift_en = 1'b0, word_ready = 1'b1, serial_in = 1'b0;
    logic [31:0] word_out;
    logic        word_valid, overflow;
    logic [4:0]  beat_cnt;
    logic [3:0]  serial_b = 4'h0;
    logic        shift_b = 1'b0;
    logic [31:0] word_b;
    logic        valid_b, overflow_b;
    logic [2:0]  cnt_b;
`ifdef DESER_PARITY_EN
    logic        perr, perr_b;
`endif
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    deser_word dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en), .flush(flush),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .beat_cnt(beat_cnt), .overflow(overflow)
`ifdef DESER_PARITY_EN
        , .word_perr(perr)
`endif
    );

    deser_word #(.WORD_W(32), .LANES(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .serial_in(serial_b), .shift_en(shift_b), .flush(1'b0),
        .word_out(word_b), .word_valid(valid_b), .word_ready(1'b1),
        .beat_cnt(cnt_b), .overflow(overflow_b)
`ifdef DESER_PARITY_EN
        , .word_perr(perr_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = data[31-i];
            shift_en  = 1'b1;
            tick();
        end
        shift_en = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data);
        beats(data, 32);
`ifdef DESER_PARITY_EN
        serial_in = ^data;
        shift_en  = 1'b1;
        tick();
        shift_en  = 1'b0;
`endif
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", word_out, 32'd0);
        check("rst_cnt", 32'(beat_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);

        send_word(32'hDEADBEEF);
        check("deadbeef_valid", 32'(word_valid), 32'd1);
        check("deadbeef_word", word_out, 32'hDEADBEEF);
        check("deadbeef_cnt", 32'(beat_cnt), 32'd0);
        tick();
        check("deadbeef_valid_clear", 32'(word_valid), 32'd0);

        word_ready = 1'b0;
        send_word(32'h11111111);
        check("bp_first_valid", 32'(word_valid), 32'd1);
        check("bp_first_word", word_out, 32'h11111111);
        check("bp_first_ovf", 32'(overflow), 32'd0);
        send_word(32'h22222222);
        check("bp_hold_word", word_out, 32'h11111111);
        check("bp_ovf_set", 32'(overflow), 32'd1);
        word_ready = 1'b1;
        tick();
        check("bp_xfer_clear", 32'(word_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        beats(32'hFFFFFFFF, 10);
        check("flush_pre_cnt", 32'(beat_cnt), 32'd10);
        flush     = 1'b1;
        shift_en  = 1'b1;
        serial_in = 1'b1;
        tick();
        flush    = 1'b0;
        shift_en = 1'b0;
        check("flush_cnt", 32'(beat_cnt), 32'd0);
        check("flush_ovf_kept", 32'(overflow), 32'd1);
        check("flush_word_kept", word_out, 32'h11111111);
        send_word(32'hA5A5A5A5);
        check("flush_word", word_out, 32'hA5A5A5A5);
        check("flush_valid", 32'(word_valid), 32'd1);
        tick();

        beats(32'hFFFFFFFF, 20);
        check("rst_mid_pre_cnt", 32'(beat_cnt), 32'd20);
        reset     = 1'b1;
        shift_en  = 1'b1;
        serial_in = 1'b1;
        tick();
        reset    = 1'b0;
        shift_en = 1'b0;
        check("rst_mid_cnt", 32'(beat_cnt), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        check("rst_mid_word", word_out, 32'd0);
        send_word(32'h0000FFFF);
        check("rst_mid_new_word", word_out, 32'h0000FFFF);
        check("rst_mid_new_valid", 32'(word_valid), 32'd1);
        check("rst_mid_new_ovf", 32'(overflow), 32'd0);

        // each lane group is bit-reversed on entry, so feed reversed nibbles to build 0x87654321
        shift_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            serial_b = rev4(4'(k));
            tick();
        end
        shift_b = 1'b0;
        check("lanes4_mid_cnt", 32'(cnt_b), 32'd4);
        shift_b = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            serial_b = rev4(4'(k));
            tick();
        end
`ifdef DESER_PARITY_EN
        serial_b = {3'b000, ^32'h87654321};
        tick();
`endif
        shift_b = 1'b0;
        check("lanes4_word", word_b, 32'h87654321);
        check("lanes4_cnt_wrap", 32'(cnt_b), 32'd0);
        check("lanes4_valid", 32'(valid_b), 32'd1);

`ifdef DESER_PARITY_EN
        tick();
        beats(32'h00000001, 32);
        serial_in = 1'b1;
        shift_en  = 1'b1;
        tick();
        shift_en = 1'b0;
        check("parity_ok_word", word_out, 32'h00000001);
        check("parity_ok_perr", 32'(perr), 32'd0);
        tick();
        beats(32'h00000001, 32);
        serial_in = 1'b0;
        shift_en  = 1'b1;
        tick();
        shift_en = 1'b0;
        check("parity_bad_perr", 32'(perr), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/deser_word.md
DESER_WORD -- requirements
Module: deser_word

Interface
REQ-001 Parameter WORD_W, default 32: output word width; SHALL be a multiple of LANES and at least 2*LANES.
REQ-002 Parameter LANES, default 1: bits accepted per shift beat; legal values 1, 2, 4.
REQ-003 Parameter MSB_FIRST, default 1: 1 = first beat lands in the MSBs of the word; 0 = first beat lands in the LSBs.
REQ-004 Derived quantities SHALL be BEATS = WORD_W/LANES and CW = $clog2(BEATS).
REQ-005 Port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: reset; synchronous, active-high.
REQ-007 Port serial_in, input, LANES: beat data; bit LANES-1 is the earliest bit in time.
REQ-008 Port shift_en, input, 1: beat strobe; a beat SHALL be accepted on any cycle with shift_en=1 and flush=0.
REQ-009 Port flush, input, 1: discards the partial word.
REQ-010 Port word_out, output, WORD_W: held word.
REQ-011 Port word_valid, output, 1: word_out is valid.
REQ-012 Port word_ready, input, 1: consumer accepts; a transfer occurs when word_valid=1 and word_ready=1.
REQ-013 Port beat_cnt, output, CW: beats of the current partial word.
REQ-014 Port overflow, output, 1: sticky flag; a completed word was dropped.
REQ-015 Port word_perr, output, 1: parity error qualifying word_out; present only with DESER_PARITY_EN.

Function
REQ-016 With MSB_FIRST=1, an accepted beat SHALL update the shift register to {shreg[WORD_W-LANES-1:0], serial_in}.
REQ-017 With MSB_FIRST=0, an accepted beat SHALL update the shift register to {serial_in, shreg[WORD_W-1:LANES]}, with serial_in bit order reversed when LANES>1 so the earliest bit is least significant.
REQ-018 beat_cnt SHALL increment on each accepted data beat; the beat accepted with beat_cnt=BEATS-1 completes the word and wraps beat_cnt to 0.
REQ-019 On completion, the finished word, including the final beat, SHALL be loaded into word_out and word_valid SHALL be 1 on the following cycle (latency 1).
REQ-020 Streaming SHALL be bubble-free: a beat is accepted on the completion cycle and every later cycle without stall.
REQ-021 While word_valid=1 and word_ready=0, word_out and word_perr SHALL hold stable.
REQ-022 A transfer with no simultaneous completion SHALL clear word_valid on the next cycle.
REQ-023 Completion coinciding with a transfer SHALL load the new word, and word_valid SHALL remain 1.
REQ-024 Completion while word_valid=1 and word_ready=0 SHALL drop the new word, retain the held word, and set overflow.
REQ-025 overflow SHALL remain set until reset.
REQ-026 flush=1 SHALL clear the shift register and beat_cnt, override shift_en in the same cycle, and leave word_out, word_valid and overflow unchanged.
REQ-027 Beats SHALL NOT be accepted while reset=1.

Reset
REQ-028 While reset=1, the shift register, beat_cnt, word_out, word_valid, overflow, word_perr and the parity FSM SHALL be cleared to 0 / DATA on the next edge.
REQ-029 Reset asserted mid-word SHALL discard the partial word; the first beat after reset deasserts is beat 0.

Configuration
REQ-030 With macro DESER_PARITY_EN defined, a two-state FSM SHALL be present: DATA -> PARITY on the accepted beat with beat_cnt=BEATS-1; PARITY -> DATA on the next accepted beat.
REQ-031 With DESER_PARITY_EN defined, the PARITY beat SHALL carry the even-parity bit on serial_in[0], with other lanes ignored, and completion SHALL occur on the PARITY beat.
REQ-032 With DESER_PARITY_EN defined, word_perr SHALL be loaded together with word_out as (XOR of the word) XOR serial_in[0].
REQ-033 With DESER_PARITY_EN defined, flush or reset SHALL return the FSM to DATA.
REQ-034 Without DESER_PARITY_EN, there SHALL be no PARITY state, no parity beat and no word_perr port; completion follows REQ-018.

Verification
REQ-035 Defaults, word_ready=1, 0xDEADBEEF sent MSB-first on beats at cycles 0-31 -> word_valid=1 at cycle 32 with word_out=0xDEADBEEF, then 0 at cycle 33.
REQ-036 LANES=4, MSB_FIRST=0, nibbles 0x1..0x8 on 8 consecutive beats -> word_out=0x87654321, beat_cnt wraps to 0.
REQ-037 word_ready=0, two back-to-back words 0x11111111 and 0x22222222 -> word_out stays 0x11111111, overflow=1 at the cycle after the second completion; raising word_ready transfers 0x11111111 only.
REQ-038 Flush after 10 beats, then 32 beats of 0xA5A5A5A5 -> word_out=0xA5A5A5A5, with none of the first 10 bits present.
REQ-039 Reset asserted after 20 beats, then a full word 0x0000FFFF -> word_out=0x0000FFFF and overflow=0.
REQ-040 With DESER_PARITY_EN, word 0x00000001 followed by parity beat 1 -> word_perr=0; the same word with parity beat 0 -> word_perr=1.
